// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, issues single-outstanding word reads to imem and buffers results for decode.
// Define IFU_PERF_EN to add perf_fetch_cnt (instructions accepted by decode).
module ifu_fetch #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             inst_valid,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc,
    input  logic             inst_ready
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]      perf_fetch_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] req_pc;
    logic [WIDTH-1:0] buf_inst [DEPTH];
    logic [WIDTH-1:0] buf_pc   [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_after;
    logic             push;
    logic             pop;
    logic             room_after;
    logic             stale_pending;
    logic [WIDTH-1:0] redirect_target;
    logic             unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign push        = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign pop         = inst_valid && inst_ready;
    assign count_after = count + CW'(push) - CW'(pop);
    assign room_after  = count_after < FULL;

    // A redirect must wait out a granted-but-unreturned read so its data is never mistaken for the new path.
    assign stale_pending = ((state == REQ) && imem_gnt) ||
                           (((state == WAIT) || (state == DROP)) && !imem_rvalid);

    assign imem_addr  = pc;
    assign inst_valid = count != '0;
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_pc   <= '0;
            imem_req <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_target;
            if (stale_pending) begin
                state    <= DROP;
                imem_req <= 1'b0;
            end else begin
                state    <= REQ;
                imem_req <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (count < FULL) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        req_pc   <= pc;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pc <= pc + WIDTH'(4);
                        if (room_after) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            imem_req <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Redirect flushes the whole buffer and overrides any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_inst[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]   <= req_pc;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_after;
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
        end else if (pop && !redirect_valid) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed and randomized checks of ifu_fetch against a queue-based fetch/buffer model.
// Define IFU_PERF_EN to also check perf_fetch_cnt.
module tb_ifu_fetch;

    localparam int          WIDTH    = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(
        .WIDTH(WIDTH),
        .RESET_PC(RESET_PC),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .inst_ready(inst_ready)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      buf_q[$];
    logic [31:0] gnt_log[$];
    logic [31:0] pop_log[$];

    int n_checks = 0;
    int n_fail = 0;

    // Memory responder: one outstanding read, answered out_cnt cycles after grant.
    bit          out_busy = 1'b0;
    bit          out_stale = 1'b0;
    int          out_cnt = 0;
    logic [31:0] out_addr = '0;
    logic [31:0] out_data = '0;

    logic [31:0] fetch_pc = RESET_PC;
    int          perf_model = 0;
    int          cyc = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;

    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          redir_pct = 0;
    int          dly_min = 1;
    int          dly_max = 1;
    bit          const_data = 1'b1;
    bit          redir_now = 1'b0;
    bit          redir_on_rvalid = 1'b0;
    logic [31:0] redir_target = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Async reset asserted between clock edges; outputs are checked before any edge arrives.
    task automatic applyReset(input bit mid_wait);
        @(negedge clk);
        if (mid_wait) begin
            checkOutput("pre_reset_inst_valid", 32'(inst_valid), 32'd1);
            checkOutput("pre_reset_req_low", 32'(imem_req), 32'd0);
        end
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_inst_pc", inst_pc, 32'd0);
`ifdef IFU_PERF_EN
        checkOutput("rst_perf", perf_fetch_cnt, 32'd0);
`endif
        buf_q.delete();
        gnt_log.delete();
        pop_log.delete();
        out_busy        = 1'b0;
        out_stale       = 1'b0;
        fetch_pc        = RESET_PC;
        perf_model      = 0;
        cyc             = 0;
        first_req_cyc   = -1;
        first_valid_cyc = -1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // One cycle: check outputs at the falling edge, drive inputs, then advance the model past the rising edge.
    task automatic applyStimulus();
        entry_t e;
        bit     do_pop;
        bit     forced;
        @(negedge clk);
        cyc++;
        checkOutput("inst_valid", 32'(inst_valid), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            checkOutput("inst_pc", inst_pc, buf_q[0].pc);
            checkOutput("inst", inst, buf_q[0].data);
        end
        if (out_busy) checkOutput("req_while_outstanding", 32'(imem_req), 32'd0);
        if (buf_q.size() >= DEPTH) checkOutput("req_while_full", 32'(imem_req), 32'd0);
`ifdef IFU_PERF_EN
        checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'(perf_model));
`endif
        if (imem_req && first_req_cyc < 0) first_req_cyc = cyc;
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
        imem_rvalid = out_busy && (out_cnt == 1);
        imem_rdata  = imem_rvalid ? out_data : $urandom();
        inst_ready  = $urandom_range(99) < ready_pct;
        forced      = redir_now || (redir_on_rvalid && imem_rvalid && buf_q.size() == 1);
        if (forced) begin
            redir_now       = 1'b0;
            redir_on_rvalid = 1'b0;
            redirect_valid  = 1'b1;
            redirect_pc     = redir_target;
        end else begin
            redirect_valid = $urandom_range(99) < redir_pct;
            redirect_pc    = $urandom();
        end

        do_pop = (buf_q.size() != 0) && inst_ready;
        if (redirect_valid) begin
            buf_q.delete();
        end else begin
            if (do_pop) begin
                pop_log.push_back(buf_q[0].pc);
                void'(buf_q.pop_front());
                perf_model++;
            end
            if (imem_rvalid && !out_stale) begin
                e.pc   = out_addr;
                e.data = out_data;
                buf_q.push_back(e);
            end
        end
        if (imem_rvalid) begin
            out_busy = 1'b0;
        end else if (out_busy) begin
            out_cnt--;
            if (redirect_valid) out_stale = 1'b1;
        end
        if (imem_gnt) begin
            checkOutput("grant_addr", imem_addr, fetch_pc);
            gnt_log.push_back(imem_addr);
            out_busy  = 1'b1;
            out_stale = redirect_valid;
            out_addr  = fetch_pc;
            out_cnt   = $urandom_range(dly_max, dly_min);
            out_data  = const_data ? 32'h0000_0013 : $urandom();
            fetch_pc  = fetch_pc + 32'd4;
        end
        if (redirect_valid) fetch_pc = {redirect_pc[31:2], 2'b00};
    endtask

    initial begin
        $display("[TB] ifu_fetch test start");

        // Stall-free memory: latency, first address, throughput.
        applyReset(1'b0);
        repeat (10) applyStimulus();
        checkOutput("first_req_cycle", 32'(first_req_cyc), 32'd1);
        checkOutput("valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        checkOutput("throughput_grants", 32'(gnt_log.size()), 32'd5);
        if (gnt_log.size() >= 3) begin
            checkOutput("a_gnt0", gnt_log[0], 32'h8000_0000);
            checkOutput("a_gnt1", gnt_log[1], 32'h8000_0004);
            checkOutput("a_gnt2", gnt_log[2], 32'h8000_0008);
        end
        checkOutput("a_pop_count", 32'(pop_log.size() >= 1), 32'd1);
        if (pop_log.size() >= 1) checkOutput("a_first_pop_pc", pop_log[0], 32'h8000_0000);

        // Decode stalled: buffer fills to DEPTH, fetch stops, head holds.
        applyReset(1'b0);
        ready_pct = 0;
        repeat (10) applyStimulus();
        checkOutput("b_req_low_when_full", 32'(imem_req), 32'd0);
        checkOutput("b_head_pc_hold", inst_pc, 32'h8000_0000);
        checkOutput("b_grants_eq_depth", 32'(gnt_log.size()), 32'(DEPTH));
        ready_pct = 100;
        repeat (6) applyStimulus();
        checkOutput("b_pops", 32'(pop_log.size() >= 2 && gnt_log.size() >= 3), 32'd1);
        if (pop_log.size() >= 2 && gnt_log.size() >= 3) begin
            checkOutput("b_pop0", pop_log[0], 32'h8000_0000);
            checkOutput("b_pop1", pop_log[1], 32'h8000_0004);
            checkOutput("b_resume_addr", gnt_log[2], 32'h8000_0008);
        end

        // Redirect while waiting on a slow read.
        applyReset(1'b0);
        dly_min = 3;
        dly_max = 3;
        const_data = 1'b0;
        for (int i = 0; i < 10 && !out_busy; i++) applyStimulus();
        checkOutput("c_first_grant", 32'(gnt_log.size()), 32'd1);
        redir_now = 1'b1;
        redir_target = 32'h8000_0103;
        gnt_log.delete();
        pop_log.delete();
        repeat (12) applyStimulus();
        checkOutput("c_progress", 32'(gnt_log.size() >= 1 && pop_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1 && pop_log.size() >= 1) begin
            checkOutput("c_redirect_addr", gnt_log[0], 32'h8000_0100);
            checkOutput("c_first_pc", pop_log[0], 32'h8000_0100);
        end

        // Redirect coinciding with rvalid while one entry is buffered.
        applyReset(1'b0);
        ready_pct = 0;
        dly_min = 1;
        dly_max = 1;
        redir_target = 32'h8000_0200;
        redir_on_rvalid = 1'b1;
        for (int i = 0; i < 12 && redir_on_rvalid; i++) applyStimulus();
        checkOutput("d_redirect_fired", 32'(redir_on_rvalid), 32'd0);
        gnt_log.delete();
        applyStimulus();
        checkOutput("d_flushed_valid", 32'(inst_valid), 32'd0);
        checkOutput("d_next_addr", imem_addr, 32'h8000_0200);
        repeat (3) applyStimulus();
        checkOutput("d_grant_seen", 32'(gnt_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1) checkOutput("d_grant_addr", gnt_log[0], 32'h8000_0200);

        // Asynchronous reset in WAIT with a valid head.
        redir_on_rvalid = 1'b0;
        applyReset(1'b0);
        dly_min = 3;
        dly_max = 3;
        for (int i = 0; i < 12 && !(out_busy && buf_q.size() != 0); i++) applyStimulus();
        applyReset(1'b1);
        repeat (3) applyStimulus();
        checkOutput("e_grant_seen", 32'(gnt_log.size() >= 1), 32'd1);
        if (gnt_log.size() >= 1) checkOutput("e_restart_addr", gnt_log[0], RESET_PC);

        // PC wrap at the top of the address space.
        applyReset(1'b0);
        ready_pct = 100;
        dly_min = 1;
        dly_max = 1;
        gnt_pct = 0;
        redir_now = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        applyStimulus();
        gnt_pct = 100;
        for (int i = 0; i < 12 && pop_log.size() < 2; i++) applyStimulus();
        ready_pct = 0;
        applyStimulus();
        checkOutput("f_pop_count", 32'(pop_log.size()), 32'd2);
        if (gnt_log.size() >= 2 && pop_log.size() >= 2) begin
            checkOutput("f_gnt0", gnt_log[0], 32'hFFFF_FFFC);
            checkOutput("f_gnt1", gnt_log[1], 32'h0000_0000);
            checkOutput("f_pop0", pop_log[0], 32'hFFFF_FFFC);
            checkOutput("f_pop1", pop_log[1], 32'h0000_0000);
        end
`ifdef IFU_PERF_EN
        checkOutput("f_perf_two", perf_fetch_cnt, 32'd2);
`endif

        // Random traffic: grant/rvalid jitter, decode back-pressure, random redirects.
        applyReset(1'b0);
        gnt_pct = 60;
        ready_pct = 60;
        redir_pct = 4;
        dly_min = 1;
        dly_max = 3;
        const_data = 1'b0;
        repeat (1500) applyStimulus();
        ready_pct = 20;
        gnt_pct = 80;
        repeat (1500) applyStimulus();
        checkOutput("g_progress", 32'(pop_log.size() > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit. Owns the PC and issues word reads to instruction memory.
- Buffers returned instructions and hands them, tagged with their PC, to the decode stage through a valid/ready handshake.
- Sits between the instruction memory port and the IDU instruction input.
- Accepts PC redirects from the EXU branch logic and discards wrong-path fetches.

Parameters:
- WIDTH, 32, data/address width (PC, instruction, memory address).
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- imem_req  output  1  read request, held until granted.
- imem_addr  output  WIDTH  read address, word aligned, stable while imem_req && !imem_gnt.
- imem_gnt  input  1  memory accepted request this cycle.
- imem_rvalid  input  1  read data valid; at least one cycle after gnt, in order.
- imem_rdata  input  WIDTH  instruction word.
- redirect_valid  input  1  one-cycle pulse: fetch from redirect_pc.
- redirect_pc  input  WIDTH  redirect target; bits [1:0] ignored, forced to 0.
- inst_valid  output  1  buffer head valid to IDU.
- inst  output  WIDTH  instruction at buffer head.
- inst_pc  output  WIDTH  PC of inst.
- inst_ready  input  1  IDU accepts head this cycle.
- perf_fetch_cnt  output  32  present only with IFU_PERF_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=IDLE, buffer empty.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- FSM states IDLE, REQ, WAIT, DROP. At most one outstanding request.
- IDLE→REQ when buffer free slots > 0 (count < DEPTH). First cycle after reset release: IDLE; imem_req=1 from the next cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt: go to WAIT and latch req_pc=pc.
- WAIT: on imem_rvalid, push {imem_rdata, req_pc} into the buffer and set pc=pc+4 (wraps modulo 2^WIDTH).
  - Next state is REQ if a slot remains after the push, accounting for a same-cycle pop. Otherwise IDLE.
- Buffer:
  - FIFO, head drives inst/inst_pc, inst_valid = count != 0.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle leave count unchanged, and are legal when full only if pop occurs. Push never occurs when full by FSM design.
  - inst/inst_pc hold their value while !inst_ready.
- Redirect (redirect_valid=1), highest priority. The effects below apply on the same edge:
  - Buffer flushed (count=0, inst_valid=0 next cycle). A same-cycle pop is ignored.
  - pc = {redirect_pc[WIDTH-1:2], 2'b00}.
  - IDLE or REQ without gnt: → REQ. The request is retargeted, and imem_addr changes next cycle; this is the only permitted address change before gnt.
  - REQ with gnt this cycle, or WAIT without rvalid: → DROP, because a stale response is pending.
  - WAIT with rvalid this cycle: data discarded, → REQ.
  - DROP: stays DROP; pc updated to the newest redirect.
- DROP:
  - imem_req=0.
  - On imem_rvalid: discard data, → REQ.
  - Redirect and rvalid in the same cycle: discard, → REQ with the new pc.
- Latency: with gnt in the REQ cycle and rvalid the next cycle, inst_valid rises 2 cycles after imem_req first asserts. Steady throughput is 1 instruction per 2 cycles.
- pc+4 wrap: 32'hFFFF_FFFC → 32'h0000_0000, no error.

Optional Feature:
- IFU_PERF_EN defined:
  - perf_fetch_cnt counts instructions accepted by IDU (pops not cancelled by redirect).
  - Wraps at 2^32; reset to 0.
- Undefined: port and counter absent, no other behaviour change.

Test Plan:
- Reset release, memory gnt same cycle, rvalid +1 cycle, rdata=32'h00000013, inst_ready=1 → requests at 8000_0000, 8000_0004, ...; inst_valid with inst_pc=32'h8000_0000, inst=32'h00000013.
- inst_ready=0 for 10 cycles → exactly DEPTH (2) entries buffered; imem_req=0 thereafter; inst/inst_pc stable. Release ready → pops in order 8000_0000, 8000_0004; fetch resumes at 8000_0008.
- Redirect to 32'h8000_0103 while in WAIT (rvalid delayed 3 cycles) → stale rdata never reaches IDU; next request addr=32'h8000_0100; first inst_pc=32'h8000_0100.
- Redirect in same cycle as rvalid with buffer holding 1 entry → buffer empty next cycle; inst_valid=0; next imem_addr=redirect target.
- Assert rst low mid-WAIT with inst_valid=1 → outputs reset immediately (asynchronous); after release first request addr=RESET_PC.
- redirect_pc=32'hFFFF_FFFC, stall-free memory → fetch addrs FFFF_FFFC then 0000_0000. With IFU_PERF_EN, perf_fetch_cnt=2 after both are accepted.
